// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master.
// Burst/response codes, FSM state type and the AxSIZE helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_e;

  // AxSIZE encoding: log2 of the beat width in bytes.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    axi_size = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) axi_size = i[2:0];
    end
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 bus between the burst master and an AXI4 slave.
// Ports: AW/W/B/AR/R channels; modports master and slave.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master.
// Ports: clk/rst; cmd_* command; wr_* write beats; rd_* read beats;
// done/done_resp/done_err completion pulse; busy; m_axi AXI4 bus.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  output logic                  busy,
  axi_burst_master_if.master    m_axi
);

  localparam logic [2:0] SIZE = axi_size(STRB_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [1:0]            done_resp_q, done_resp_d;
  logic                  done_err_q, done_err_d;

  logic last_beat;
  logic wr_st;
  logic rd_st;
  logic w_fire;
  logic r_fire;
  logic [1:0] resp_worst;
  logic unused_ids;

  assign last_beat = cnt_q == len_q;
  assign wr_st = state_q == ST_WR_DATA;
  assign rd_st = state_q == ST_RD_DATA;
  assign w_fire = wr_st & wr_valid & m_axi.wready;
  assign r_fire = rd_st & m_axi.rvalid & rd_ready;

  // Higher code is worse: DECERR > SLVERR > EXOKAY > OKAY.
  assign resp_worst = (m_axi.rresp > resp_q) ?
                      m_axi.rresp : resp_q;

  assign unused_ids = ^{m_axi.bid, m_axi.rid};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    err_d       = err_q;
    done_d      = 1'b0;
    done_resp_d = RESP_OKAY;
    done_err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          cnt_d   = '0;
          resp_d  = RESP_OKAY;
          err_d   = 1'b0;
          state_d = cmd_write ? ST_WR_ADDR
                              : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (m_axi.awready) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (w_fire) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          done_d      = 1'b1;
          done_resp_d = m_axi.bresp;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_fire) begin
          cnt_d  = cnt_q + 8'd1;
          resp_d = resp_worst;
          err_d  = err_q | (m_axi.rlast != last_beat);
          if (last_beat) begin
            done_d      = 1'b1;
            done_resp_d = resp_d;
            done_err_d  = err_d;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      resp_q      <= RESP_OKAY;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= RESP_OKAY;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
      done_err_q  <= done_err_d;
    end
  end

  // Held low during reset so no command slips in on the reset edge.
  assign cmd_ready = (state_q == ST_IDLE) & ~rst;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign done_err  = done_err_q;

  assign m_axi.awid    = id_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = SIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = state_q == ST_WR_ADDR;

  assign m_axi.wdata  = wr_data;
  assign m_axi.wstrb  = wr_strb;
  assign m_axi.wlast  = wr_st & last_beat;
  assign m_axi.wvalid = wr_st & wr_valid;
  assign wr_ready     = wr_st & m_axi.wready;

  assign m_axi.bready = state_q == ST_WR_RESP;

  assign m_axi.arid    = id_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = SIZE;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = state_q == ST_RD_ADDR;

  assign rd_data      = m_axi.rdata;
  assign rd_last      = rd_st & last_beat;
  assign rd_valid     = rd_st & m_axi.rvalid;
  assign m_axi.rready = rd_st & rd_ready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI RAM slave,
// byte-level reference memory and scoreboard queues.
module tb_axi_burst_master;
  import axi_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic [1:0]    done_resp;
  logic          done_err;
  logic          busy;

  axi_burst_master_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ID_WIDTH(IW), .STRB_WIDTH(SW)
  ) axi ();

  axi_burst_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .done_err(done_err), .busy(busy),
    .m_axi(axi.master)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] id;
  } acmd_t;
  typedef struct { logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [31:0] data; logic last; } rexp_t;
  typedef struct { logic [1:0] resp; logic err; } dexp_t;

  acmd_t  a_q[$];
  rbeat_t rb_q[$];
  rexp_t  rd_q[$];
  dexp_t  d_q[$];
  logic [1:0] b_q[$];

  logic [7:0]  ref_mem [256];
  logic [7:0]  slv_mem [256];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int done_exp = 0;
  int rr_mode = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slv_word(input logic [7:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = slv_mem[8'(int'(a) + k)];
    return w;
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(int'(a) + k)];
    return w;
  endfunction

  // AXI RAM slave: samples handshakes at negedge, updates after posedge.
  initial begin : slave
    int ph;
    int beat;
    int blen;
    logic [7:0] base, cur_id, ix;
    logic r, h_aw, h_ar, h_w, h_b, h_r, wl;
    logic [7:0] aaddr, alen, aid;
    logic [2:0] asz, aprot;
    logic [1:0] abst;
    logic       alk;
    logic [3:0] acache, ws;
    logic [31:0] wd;
    rbeat_t cb;
    acmd_t ea;
    ph = 0; beat = 0; blen = 0; base = '0; cur_id = '0;
    cb.resp = RESP_OKAY; cb.last = 1'b0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    axi.bresp = 0; axi.bid = 0; axi.arready = 0;
    axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    axi.rlast = 0; axi.rid = 0;
    forever begin
      @(negedge clk);
      r    = rst;
      h_aw = axi.awvalid && axi.awready;
      h_ar = axi.arvalid && axi.arready;
      if (axi.awvalid) begin
        aaddr = axi.awaddr; alen = axi.awlen; aid = axi.awid;
        asz = axi.awsize; abst = axi.awburst; alk = axi.awlock;
        acache = axi.awcache; aprot = axi.awprot;
      end else begin
        aaddr = axi.araddr; alen = axi.arlen; aid = axi.arid;
        asz = axi.arsize; abst = axi.arburst; alk = axi.arlock;
        acache = axi.arcache; aprot = axi.arprot;
      end
      h_w = axi.wvalid && axi.wready;
      wd  = axi.wdata;
      ws  = axi.wstrb;
      wl  = axi.wlast;
      h_b = axi.bvalid && axi.bready;
      h_r = axi.rvalid && axi.rready;
      @(posedge clk); #1;
      if (r) begin
        ph = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
      end else begin
        if (h_aw || h_ar) begin
          if (a_q.size() == 0) check("addr_unexpected", 1, 0);
          else begin
            ea = a_q.pop_front();
            check("addr_fields",
              {h_aw, aaddr, alen, aid, asz, abst, alk, acache, aprot},
              {ea.wr, ea.addr, ea.len, ea.id, 3'd2, BURST_INCR,
               1'b0, 4'd0, 3'd0});
          end
          base = aaddr; blen = int'(alen); beat = 0; cur_id = aid;
          if (h_aw) begin
            ph = 1;
            axi.bresp = (b_q.size() != 0) ? b_q.pop_front() : RESP_OKAY;
          end else begin
            ph = 3;
            if (rb_q.size() != 0) cb = rb_q.pop_front();
            else check("rbeat_underflow", 1, 0);
          end
        end
        if (h_w) begin
          for (int k = 0; k < 4; k++) begin
            ix = 8'(int'(base) + 4*beat + k);
            if (ws[k]) slv_mem[ix] = wd[8*k +: 8];
          end
          check("wlast", wl, beat == blen);
          beat++;
          if (beat > blen) ph = 2;
        end
        if (h_b) ph = 0;
        if (h_r) begin
          beat++;
          if (beat > blen) ph = 0;
          else if (rb_q.size() != 0) cb = rb_q.pop_front();
          else check("rbeat_underflow", 1, 0);
        end
        axi.awready = (ph == 0) && ($urandom_range(0, 3) != 0);
        axi.arready = (ph == 0) && ($urandom_range(0, 3) != 0);
        axi.wready  = (ph == 1) && ($urandom_range(0, 3) != 0);
        axi.bvalid  = ph == 2;
        axi.bid     = cur_id;
        if (ph == 3) begin
          if (!axi.rvalid || h_r)
            axi.rvalid = $urandom_range(0, 3) != 0;
          axi.rdata = slv_word(8'(int'(base) + 4*beat));
          axi.rresp = cb.resp;
          axi.rlast = cb.last;
          axi.rid   = cur_id;
        end else begin
          axi.rvalid = 0;
          axi.rlast  = 0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    rexp_t re;
    dexp_t de;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid && rd_ready) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            re = rd_q.pop_front();
            check("rd_beat", {rd_data, rd_last}, {re.data, re.last});
          end
        end
        if (done) begin
          done_seen++;
          if (d_q.size() == 0) check("done_unexpected", 1, 0);
          else begin
            de = d_q.pop_front();
            check("done", {done_resp, done_err}, {de.resp, de.err});
          end
        end
        if (cmd_valid && busy) check("cmd_ready_busy", cmd_ready, 0);
      end
    end
  end

  initial begin : rd_ready_drv
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr,
                       input logic [7:0] len, input logic [7:0] id);
    int n = 0;
    logic got = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = addr; cmd_len = len; cmd_id = id;
    while (!got && n < 200) begin
      @(negedge clk);
      got = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (!got) check("cmd_timeout", 0, 1);
  endtask

  task automatic write_beats(input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      logic got = 1'b0;
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      wr_valid = 1'b1; wr_data = wbuf[i]; wr_strb = sbuf[i];
      while (!got && n < 200) begin
        @(negedge clk);
        got = wr_ready;
        step();
        n++;
      end
      if (!got) begin
        check("wr_timeout", 0, 1);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic ref_write(input logic [7:0] addr, input int nb);
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < 4; k++)
        if (sbuf[i][k]) ref_mem[8'(int'(addr) + 4*i + k)] = wbuf[i][8*k +: 8];
  endtask

  task automatic prep_write(input logic [7:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [1:0] bresp);
    acmd_t a;
    dexp_t d;
    a.wr = 1'b1; a.addr = addr; a.len = len; a.id = id;
    a_q.push_back(a);
    b_q.push_back(bresp);
    d.resp = bresp; d.err = 1'b0;
    d_q.push_back(d);
    done_exp++;
    ref_write(addr, int'(len) + 1);
  endtask

  // bad >= 0 makes the slave raise RLAST only on beat 'bad'.
  task automatic prep_read(input logic [7:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input int bad,
                           input bit rnd);
    acmd_t a;
    dexp_t d;
    rexp_t e;
    rbeat_t b;
    int r;
    d.resp = RESP_OKAY; d.err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = ref_word(8'(int'(addr) + 4*i));
      e.last = (i == int'(len));
      rd_q.push_back(e);
      r = rnd ? int'($urandom_range(0, 7)) : 0;
      b.resp = (r < 5) ? RESP_OKAY : 2'(r - 4);
      b.last = (bad >= 0) ? (i == bad) : (i == int'(len));
      rb_q.push_back(b);
      if (b.resp > d.resp) d.resp = b.resp;
      if (b.last != e.last) d.err = 1'b1;
    end
    a.wr = 1'b0; a.addr = addr; a.len = len; a.id = id;
    a_q.push_back(a);
    d_q.push_back(d);
    done_exp++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_seen < done_exp && n < 5000) begin
      step();
      n++;
    end
    if (done_seen < done_exp) begin
      check("done_timeout", 64'(done_seen), 64'(done_exp));
      done_seen = done_exp;
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input bit gaps,
                          input logic [1:0] bresp);
    prep_write(addr, len, id, bresp);
    issue(1'b1, addr, len, id);
    write_beats(int'(len) + 1, gaps);
    wait_done();
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] len,
                         input logic [7:0] id, input int bad,
                         input bit rnd);
    prep_read(addr, len, id, bad, rnd);
    issue(1'b0, addr, len, id);
    wait_done();
  endtask

  initial begin : main
    int n;
    logic got;
    logic [7:0] a8, l8;
    logic [1:0] br;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      slv_mem[i] = 8'h00;
    end

    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_axi_ctrl",
      {axi.awvalid, axi.wvalid, axi.arvalid,
       axi.bready, axi.rready, axi.wlast}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outputs", {done, done_resp, done_err, busy}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);
    step();

    rr_mode = 0;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hDEADBEEF + 32'(i);
      sbuf[i] = 4'hF;
    end
    do_write(8'h00, 8'd3, 8'h11, 1'b0, RESP_OKAY);
    do_read(8'h00, 8'd3, 8'h22, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    do_write(8'h40, 8'd7, 8'h23, 1'b1, RESP_OKAY);
    rr_mode = 1;
    do_read(8'h40, 8'd7, 8'h24, -1, 1'b0);

    wbuf[0] = 32'h12345678;
    sbuf[0] = 4'h3;
    do_write(8'hFC, 8'd0, 8'h31, 1'b0, RESP_OKAY);
    do_read(8'hFC, 8'd0, 8'h32, -1, 1'b0);

    // Command held during a busy write; read taken in the done cycle.
    rr_mode = 0;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    prep_write(8'h80, 8'd3, 8'h33, RESP_OKAY);
    issue(1'b1, 8'h80, 8'd3, 8'h33);
    prep_read(8'h80, 8'd3, 8'h44, -1, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    cmd_addr = 8'h80; cmd_len = 8'd3; cmd_id = 8'h44;
    write_beats(4, 1'b0);
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = cmd_ready;
      if (got) check("accept_in_done_cycle", done, 1);
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (!got) check("held_cmd_timeout", 0, 1);
    @(negedge clk);
    check("arvalid_after_accept", axi.arvalid, 1);
    step();
    wait_done();

    // Reset after beat 2 of a 4-beat write.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    begin
      acmd_t a;
      a.wr = 1'b1; a.addr = 8'hC0; a.len = 8'd3; a.id = 8'h55;
      a_q.push_back(a);
      b_q.push_back(RESP_OKAY);
    end
    issue(1'b1, 8'hC0, 8'd3, 8'h55);
    write_beats(2, 1'b0);
    ref_write(8'hC0, 2);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_valids",
      {axi.awvalid, axi.wvalid, axi.arvalid,
       axi.bready, axi.rready}, 0);
    check("rst_mid_busy_done", {busy, done}, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    wbuf[0] = $urandom;
    sbuf[0] = 4'hF;
    do_write(8'hD0, 8'd0, 8'h66, 1'b0, RESP_OKAY);

    // RLAST raised early by the slave.
    do_read(8'h10, 8'd1, 8'h77, 0, 1'b0);

    rr_mode = 2;
    for (int t = 0; t < 30; t++) begin
      a8 = 8'(4 * $urandom_range(0, 63));
      l8 = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) begin
        for (int i = 0; i <= int'(l8); i++) begin
          wbuf[i] = $urandom;
          sbuf[i] = 4'($urandom_range(0, 15));
        end
        br = ($urandom_range(0, 3) == 0) ?
             2'($urandom_range(1, 3)) : RESP_OKAY;
        do_write(a8, l8, 8'(t), 1'b1, br);
      end else begin
        do_read(a8, l8, 8'(t), -1, 1'b1);
      end
    end

    // Maximum length: 256 beats, address wraps in the 8-bit space.
    for (int i = 0; i < 256; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    do_write(8'h00, 8'd255, 8'h88, 1'b1, RESP_OKAY);
    do_read(8'h00, 8'd255, 8'h99, -1, 1'b0);

    repeat (5) step();
    check("queues_left",
      64'(a_q.size() + rd_q.size() + d_q.size() +
          rb_q.size() + b_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
